// File: rtl/tx_sequencer_pkg.sv
// Shared constants for the transmit sequencer and the sampler: one-hot state
// bit indices, minimum strobe period and the per-pair underrun threshold.
package tx_sequencer_pkg;

    localparam int S_IDLE   = 0;
    localparam int S_PRIME  = 1;
    localparam int S_RUN    = 2;
    localparam int S_SETTLE = 3;
    localparam int S_DONE   = 4;

    localparam logic [4:0] ST_IDLE   = 5'(1 << S_IDLE);
    localparam logic [4:0] ST_PRIME  = 5'(1 << S_PRIME);
    localparam logic [4:0] ST_RUN    = 5'(1 << S_RUN);
    localparam logic [4:0] ST_SETTLE = 5'(1 << S_SETTLE);
    localparam logic [4:0] ST_DONE   = 5'(1 << S_DONE);

    localparam int TX_MIN_DIV     = 4;
    // One I/Q pair is two bytes; fewer than that in the FIFO starves a strobe.
    localparam int UNDERRUN_LEVEL = 2;

    function automatic logic [15:0] clamp_div(input logic [15:0] d, input logic [15:0] m);
        return (d < m) ? m : d;
    endfunction

endpackage

// File: rtl/tx_rate_div.sv
// Restartable strobe divider: tick in the first enabled cycle after restart,
// then once every period_m1+1 enabled cycles.
module tx_rate_div #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         restart,
    input  logic         en,
    input  logic [W-1:0] period_m1,
    output logic         tick
);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == '0) cnt <= period_m1;
            else           cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/tx_sequencer.sv
// Burst controller for the transmit sample path: prime wait, rate-divided
// sample strobes, underrun counting and completion pulse.
// Build option: define TX_SEQ_UNDERRUN_ABORT_EN to end a burst on the first
// starved strobe instead of only counting it.
module tx_sequencer
    import tx_sequencer_pkg::*;
#(
    parameter int FIFO_AW       = 9,
    parameter int PRIME_LEVEL   = 64,
    parameter int MIN_DIV       = TX_MIN_DIV,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      burst_len,
    input  logic [15:0]      rate_div,
    input  logic [FIFO_AW:0] fifo_level,
    output logic             sample_stb,
    output logic             tx_active,
    output logic             done,
    output logic [7:0]       underrun_cnt,
    output logic [15:0]      pairs_sent
);

    localparam logic [FIFO_AW:0] PRIME_THR   = (FIFO_AW+1)'(PRIME_LEVEL);
    localparam logic [FIFO_AW:0] STARVE_THR  = (FIFO_AW+1)'(UNDERRUN_LEVEL);
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    logic [4:0]  state;
    logic [15:0] len_q;
    logic [15:0] div_q;
    logic [7:0]  settle_cnt;
    logic        tick;
    logic        starved;
    logic        last_pair;

    assign starved   = fifo_level < STARVE_THR;
    assign last_pair = (pairs_sent + 16'd1) == len_q;

    // Held at zero through PRIME so the first RUN cycle ticks immediately.
    tx_rate_div #(.W(16)) u_div (
        .clk       (clk),
        .rst       (rst),
        .restart   (state == ST_PRIME),
        .en        ((state == ST_RUN) && !abort),
        .period_m1 (div_q - 16'd1),
        .tick      (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            len_q        <= '0;
            div_q        <= 16'(MIN_DIV);
            settle_cnt   <= '0;
            sample_stb   <= 1'b0;
            tx_active    <= 1'b0;
            done         <= 1'b0;
            underrun_cnt <= '0;
            pairs_sent   <= '0;
        end else begin
            sample_stb <= 1'b0;
            done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q        <= burst_len;
                        div_q        <= clamp_div(rate_div, 16'(MIN_DIV));
                        pairs_sent   <= '0;
                        underrun_cnt <= '0;
                        if (burst_len == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_PRIME;
                            tx_active <= 1'b1;
                        end
                    end
                end
                ST_PRIME: begin
                    if (abort) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end else if (fifo_level >= PRIME_THR) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end else if (tick) begin
                        sample_stb <= 1'b1;
                        pairs_sent <= pairs_sent + 16'd1;
                        if (starved && underrun_cnt != 8'hff)
                            underrun_cnt <= underrun_cnt + 8'd1;
`ifdef TX_SEQ_UNDERRUN_ABORT_EN
                        if (last_pair || starved) begin
`else
                        if (last_pair) begin
`endif
                            state      <= ST_SETTLE;
                            settle_cnt <= '0;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state     <= ST_DONE;
                        tx_active <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state        <= ST_IDLE;
                    tx_active    <= 1'b0;
                    settle_cnt   <= '0;
                    underrun_cnt <= '0;
                    pairs_sent   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_sequencer.sv
// Directed bench for tx_sequencer: strobe spacing, prime wait, underrun,
// abort, zero-length burst and mid-burst reset.
module tb_tx_sequencer;

    localparam int FIFO_AW = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [15:0]      burst_len = '0;
    logic [15:0]      rate_div = '0;
    logic [FIFO_AW:0] fifo_level = '0;
    logic             sample_stb;
    logic             tx_active;
    logic             done;
    logic [7:0]       underrun_cnt;
    logic [15:0]      pairs_sent;

    tx_sequencer #(.FIFO_AW(FIFO_AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .burst_len    (burst_len),
        .rate_div     (rate_div),
        .fifo_level   (fifo_level),
        .sample_stb   (sample_stb),
        .tx_active    (tx_active),
        .done         (done),
        .underrun_cnt (underrun_cnt),
        .pairs_sent   (pairs_sent)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int stb_q[$];
    int done_q[$];
    always @(negedge clk) begin
        if (sample_stb) stb_q.push_back(cyc);
        if (done)       done_q.push_back(cyc);
    end

    int checks = 0;
    int errors = 0;
    int c0;
    int cx;
    int s2;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int stb_at(input int i);
        return (i < stb_q.size()) ? stb_q[i] : -1000;
    endfunction

    function automatic int done_at(input int i);
        return (i < done_q.size()) ? done_q[i] : -1000;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic launch(input int len, input int div, input bit with_abort);
        stb_q.delete();
        done_q.delete();
        burst_len = 16'(len);
        rate_div  = 16'(div);
        start     = 1'b1;
        abort     = with_abort;
        c0        = cyc;
        step();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_q.size() == 0 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_q.size() > 0), 1);
        step(3);
    endtask

    task automatic wait_stb(input string tag, input int count, input int budget);
        int n = 0;
        while (stb_q.size() < count && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_stb_seen"}, 32'(stb_q.size() >= count), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        chk("rst_stb",      32'(sample_stb),   0);
        chk("rst_active",   32'(tx_active),    0);
        chk("rst_done",     32'(done),         0);
        chk("rst_underrun", 32'(underrun_cnt), 0);
        chk("rst_pairs",    32'(pairs_sent),   0);
        rst = 1'b0;
        step(2);

        // 1: primed FIFO, len 3, period 10
        fifo_level = 100;
        launch(3, 10, 1'b0);
        chk("t1_active", 32'(tx_active), 1);
        wait_done("t1", 100);
        chk("t1_nstb",     32'(stb_q.size()), 3);
        chk("t1_latency",  32'(stb_at(0) - c0), 3);
        chk("t1_gap0",     32'(stb_at(1) - stb_at(0)), 10);
        chk("t1_gap1",     32'(stb_at(2) - stb_at(1)), 10);
        chk("t1_done_lat", 32'(done_at(0) - stb_at(2)), 4);
        chk("t1_pairs",    32'(pairs_sent), 3);
        chk("t1_underrun", 32'(underrun_cnt), 0);
        chk("t1_idle",     32'(tx_active), 0);

        // 2: period below minimum clamps to 4; abort alongside start is ignored
        launch(2, 1, 1'b1);
        wait_done("t2", 60);
        chk("t2_nstb",    32'(stb_q.size()), 2);
        chk("t2_latency", 32'(stb_at(0) - c0), 3);
        chk("t2_gap",     32'(stb_at(1) - stb_at(0)), 4);
        chk("t2_pairs",   32'(pairs_sent), 2);

        // 3: FIFO below prime level holds off strobes
        fifo_level = 10;
        launch(1, 4, 1'b0);
        step(20);
        chk("t3_no_stb", 32'(stb_q.size()), 0);
        chk("t3_active", 32'(tx_active), 1);
        cx = cyc;
        fifo_level = 64;
        wait_done("t3", 60);
        chk("t3_nstb",     32'(stb_q.size()), 1);
        chk("t3_first",    32'(stb_at(0) - cx), 2);
        chk("t3_done_lat", 32'(done_at(0) - stb_at(0)), 4);
        fifo_level = 100;

        // 4: FIFO drains to 1 byte once RUN is entered
        launch(5, 4, 1'b0);
        step();
        fifo_level = 1;
        wait_done("t4", 100);
`ifdef TX_SEQ_UNDERRUN_ABORT_EN
        chk("t4_nstb",     32'(stb_q.size()), 1);
        chk("t4_underrun", 32'(underrun_cnt), 1);
        chk("t4_pairs",    32'(pairs_sent), 1);
        chk("t4_done_lat", 32'(done_at(0) - stb_at(0)), 4);
`else
        chk("t4_nstb",     32'(stb_q.size()), 5);
        chk("t4_underrun", 32'(underrun_cnt), 5);
        chk("t4_pairs",    32'(pairs_sent), 5);
        chk("t4_gap",      32'(stb_at(4) - stb_at(3)), 4);
`endif
        fifo_level = 100;

        // 5: abort two clocks after the second strobe; stray start mid-burst
        launch(10, 5, 1'b0);
        wait_stb("t5a", 1, 40);
        step();
        burst_len = 16'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_stb("t5b", 2, 40);
        s2 = stb_at(1);
        chk("t5_gap", 32'(s2 - stb_at(0)), 5);
        step(2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_done("t5", 40);
        step(20);
        chk("t5_nstb",     32'(stb_q.size()), 2);
        chk("t5_pairs",    32'(pairs_sent), 2);
        chk("t5_ndone",    32'(done_q.size()), 1);
        chk("t5_done_lat", 32'(done_at(0) - s2), 7);

        // 6a: zero-length burst completes at once
        launch(0, 10, 1'b0);
        wait_done("t6a", 10);
        chk("t6a_done_lat", 32'(done_at(0) - c0), 1);
        chk("t6a_nstb",     32'(stb_q.size()), 0);
        chk("t6a_active",   32'(tx_active), 0);

        // 6b: reset during a strobe cycle clears everything without done
        launch(5, 10, 1'b0);
        wait_stb("t6b", 1, 20);
        chk("t6b_stb_pre", 32'(sample_stb), 1);
        #1 rst = 1'b1;
        #1;
        chk("t6b_stb",      32'(sample_stb),   0);
        chk("t6b_active",   32'(tx_active),    0);
        chk("t6b_pairs",    32'(pairs_sent),   0);
        chk("t6b_underrun", 32'(underrun_cnt), 0);
        step(2);
        rst = 1'b0;
        stb_q.delete();
        done_q.delete();
        step(30);
        chk("t6b_ndone", 32'(done_q.size()), 0);
        chk("t6b_nstb",  32'(stb_q.size()),  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
